// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte transmitter among four requesters.
// Sequences one byte at a time with an optional post-byte gap and a stall watchdog.
module uart_tx_arbiter #(
  parameter logic [15:0] GAP_CYC      = 16'd0,
  parameter logic [23:0] TIMEOUT_CYC  = 24'd1_000_000,
  parameter logic [2:0]  BAUD_DEFAULT = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        busy,
  output logic        err,
  input  logic [2:0]  cfg_baud,
  input  logic        cfg_we,
  output logic [7:0]  data_byte,
  output logic        send_en,
  output logic [2:0]  baud_set,
  input  logic        tx_done,
  input  logic        uart_state
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  owner_q, owner_d;
  logic [7:0]  data_q, data_d;
  logic        send_q, send_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  baud_q, baud_d;
  logic        pend_v_q, pend_v_d;
  logic [2:0]  pend_q, pend_d;
  logic [15:0] gap_q, gap_d;
  logic [23:0] wd_q, wd_d;

  logic [7:0]  req_byte [4];
  logic        win_found;
  logic [1:0]  win_idx;
  logic        launch;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Search ptr, ptr+1, ... mod 4; first active request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!win_found && req[ptr_q + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    data_d   = data_q;
    send_d   = 1'b0;
    grant_d  = 4'b0000;
    done_d   = 4'b0000;
    err_d    = 1'b0;
    baud_d   = baud_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    gap_d    = gap_q;
    wd_d     = wd_q;
    launch   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found && !uart_state) begin
          launch  = 1'b1;
          data_d  = req_byte[win_idx];
          send_d  = 1'b1;
          grant_d = 4'b0001 << win_idx;
          owner_d = win_idx;
          ptr_d   = win_idx + 2'd1;
          wd_d    = 24'd0;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY, S_WAIT_DONE: begin
        // tx_done takes priority over a watchdog expiry in the same cycle.
        if (tx_done) begin
          done_d = 4'b0001 << owner_q;
          if (GAP_CYC == 16'd0) begin
            state_d = S_IDLE;
          end else begin
            gap_d   = GAP_CYC - 16'd1;
            state_d = S_GAP;
          end
        end else if (wd_q == TIMEOUT_CYC - 24'd1) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 24'd1;
          if (state_q == S_WAIT_BUSY && uart_state) begin
            state_d = S_WAIT_DONE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Baud writes land directly only in an IDLE cycle that issues no grant.
    if (cfg_we) begin
      if (state_q == S_IDLE && !launch) begin
        baud_d   = cfg_baud;
        pend_v_d = 1'b0;
      end else begin
        pend_d   = cfg_baud;
        pend_v_d = 1'b1;
      end
    end else if (state_q == S_IDLE && pend_v_q) begin
      baud_d   = pend_q;
      pend_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 2'd0;
      owner_q  <= 2'd0;
      data_q   <= 8'd0;
      send_q   <= 1'b0;
      grant_q  <= 4'b0000;
      done_q   <= 4'b0000;
      err_q    <= 1'b0;
      baud_q   <= BAUD_DEFAULT;
      pend_v_q <= 1'b0;
      pend_q   <= 3'b000;
      gap_q    <= 16'd0;
      wd_q     <= 24'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
      send_q   <= send_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      baud_q   <= baud_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      gap_q    <= gap_d;
      wd_q     <= wd_d;
    end
  end

  // The done cycle still counts as busy even though the FSM is already back in IDLE.
  assign busy      = (state_q != S_IDLE) | (|done_q);
  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign data_byte = data_q;
  assign send_en   = send_q;
  assign baud_set  = baud_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART byte transmitter among four byte-producing requesters. It drives the transmitter's `data_byte`, `send_en` and `baud_set` inputs and consumes its `tx_done` and `uart_state` outputs. It sequences one byte at a time with an optional inter-byte gap and a stall watchdog. It sits between the application sources (status reporter, debug dump, etc.) and the single TX core.

## Interface
- `GAP_CYC`, 16'd0: idle cycles inserted after each byte's `tx_done` before the next grant.
- `TIMEOUT_CYC`, 24'd1_000_000: watchdog limit in WAIT_BUSY/WAIT_DONE, in clk cycles.
- `BAUD_DEFAULT`, 3'b000: `baud_set` value loaded at reset.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 4: per-requester byte request, level, held until granted.
- `req_data` in 32: byte for requester i on bits [8i+7:8i]; stable while `req[i]`=1.
- `grant` out 4: one-hot, one-cycle pulse; byte of that requester was latched.
- `done` out 4: one-hot, one-cycle pulse; granted byte finished (stop bit sent).
- `busy` out 1: high whenever FSM is not IDLE.
- `err` out 1: one-cycle pulse on watchdog expiry.
- `cfg_baud` in 3: new baud selection.
- `cfg_we` in 1: write strobe for `cfg_baud`.
- `data_byte` out 8: to TX core.
- `send_en` out 1: to TX core, one-cycle start pulse.
- `baud_set` out 3: to TX core.
- `tx_done` in 1: from TX core, one-cycle completion pulse.
- `uart_state` in 1: from TX core, high while transmitting.

## Operation
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if `req`≠0 and `uart_state`=0, pick winner by round-robin from pointer `ptr` (2 bits), searching ptr, ptr+1, … mod 4. On that edge: register `data_byte`←req_data[winner], `send_en`←1, `grant`←onehot(winner), `owner`←winner, `ptr`←winner+1 mod 4, go to WAIT_BUSY. If `uart_state`=1 in IDLE, issue nothing.
- WAIT_BUSY: `send_en` back to 0. On `uart_state`=1, go to WAIT_DONE. If `tx_done` arrives first, treat as WAIT_DONE's exit.
- WAIT_DONE: on `tx_done`=1, pulse `done[owner]` next cycle. If GAP_CYC=0, go to IDLE; otherwise load the gap counter and go to GAP.
- GAP: decrement each cycle; at 0, go to IDLE. Requests are ignored until IDLE.
- Watchdog: 24-bit counter cleared on entry to WAIT_BUSY and increments in WAIT_BUSY/WAIT_DONE. When it reaches TIMEOUT_CYC: pulse `err`, no `done`, go to IDLE. `ptr` stays advanced.
- Baud config: `cfg_we` in IDLE with no grant that cycle updates `baud_set` on the next edge. Otherwise `cfg_baud` is stored as pending and applied on the first IDLE cycle. A later write overwrites the pending value. `baud_set` never changes while `busy`=1.
- Requester duties: hold `req`/data until `grant`; may re-assert for the next byte the cycle after `grant`. A request dropped before grant is simply not served.
- `data_byte` holds the last granted byte until the next grant.

## Timing
- Reset values: `grant`=0, `done`=0, `busy`=0, `err`=0, `send_en`=0, `data_byte`=8'd0, `baud_set`=BAUD_DEFAULT, `ptr`=0, FSM=IDLE, pending cleared.
- Request to start: `req` seen in IDLE at edge n gives `send_en`/`grant` high for cycle n+1 only.
- `tx_done` at edge m gives `done` high for cycle m+1, with `busy` still high that cycle. With GAP_CYC=0, IDLE at m+1 and the earliest next `send_en` is at m+2.
- With GAP_CYC=G, the next `send_en` is no earlier than m+G+2.
- Back-to-back `send_en` pulses never occur; at most one byte is outstanding.
- Simultaneous `tx_done` and watchdog expiry: `tx_done` wins, `done` pulses, no `err`.
- Simultaneous `cfg_we` and grant in IDLE: the config goes to pending and is applied at the next IDLE.
- `rst` mid-byte: all outputs return to reset values asynchronously. The TX core's own reset governs the line.

## Test plan
- Single request: `req`=4'b0010, data 8'hA5 → `grant`=4'b0010 and `send_en` one cycle later with `data_byte`=8'hA5; core `tx_done` → `done`=4'b0010 next cycle, `busy` low after.
- Fairness: all four `req` held continuously from reset → grant order 0,1,2,3,0,1 and no requester is granted twice while another waits.
- Gap: GAP_CYC=5, two pending requests → exactly 5 idle cycles between the first `done` and the second `send_en`, counted as m+7.
- Watchdog: TIMEOUT_CYC=100, core model never raises `uart_state`/`tx_done` → `err` pulses 100 cycles after `send_en`, no `done`, `busy` drops, next request is served.
- Baud config: `cfg_we` with `cfg_baud`=3'b011 during WAIT_DONE → `baud_set` stays 3'b000 until the first IDLE cycle, then becomes 3'b011; a write in an empty IDLE applies on the next edge.
- Reset mid-transfer: assert `rst` in WAIT_DONE → all outputs at reset values immediately; after release, a `req[3]` is granted normally, with `ptr` reset to 0.
